// File: rtl/prog_ctrl_pkg.sv
// Shared types and default constants for the program run sequencer.
// Sequencer states, RUN exit causes and default END_PC / MAX_CYC values.
package prog_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } prc_state_t;

    typedef enum logic [1:0] {
        EXIT_HALT = 2'd0,
        EXIT_END  = 2'd1,
        EXIT_TMO  = 2'd2
    } prc_exit_t;

    localparam int unsigned PRC_END_PC  = 128;
    localparam int unsigned PRC_MAX_CYC = 32'h0000_FFFF;

endpackage

// File: rtl/prc_sat_counter.sv
// Saturating up-counter with synchronous clear; also exposes its next
// (incremented, saturated) value for look-ahead comparisons.
module prc_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] cnt_next_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign cnt_next_o = (cnt_q == '1) ? cnt_q : cnt_q + W'(1);
    assign cnt_o      = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_next_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/prog_run_ctrl.sv
// Run sequencer: req/done handshake, register-file clear, PC release, watchdog.
// Optional build macro PRC_STEP_EN: RUN advances one cycle per rising edge of step.
module prog_run_ctrl
    import prog_ctrl_pkg::*;
#(
    parameter int          D        = 12,
    parameter int          END_PC   = PRC_END_PC,
    parameter int          RF_DEPTH = 8,
    parameter int          CW       = 16,
    parameter int unsigned MAX_CYC  = PRC_MAX_CYC
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req,
    input  logic [D-1:0]                prog_ctr,
    input  logic                        halt,
    input  logic                        step,
    output logic                        core_rst,
    output logic                        core_en,
    output logic                        rf_clr_we,
    output logic [$clog2(RF_DEPTH)-1:0] rf_clr_addr,
    output logic                        busy,
    output logic                        done,
    output logic                        timeout,
    output logic [CW-1:0]               cyc_cnt
);

    localparam int AW = $clog2(RF_DEPTH);

    prc_state_t    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          tmo_q, tmo_d;
    logic          run_en;
    logic          cnt_clr;
    logic          exit_hit;
    prc_exit_t     exit_cause;
    logic [CW-1:0] cnt_next;

`ifdef PRC_STEP_EN
    logic step_q;
    logic en_q, en_d;

    // One enabled RUN cycle per step rising edge; never re-armed on the exit cycle.
    assign en_d   = (state_q == RUN) && !exit_hit && step && !step_q;
    assign run_en = (state_q == RUN) && en_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_q <= 1'b0;
            en_q   <= 1'b0;
        end else begin
            step_q <= step;
            en_q   <= en_d;
        end
    end
`else
    logic unused_step;

    assign unused_step = step;
    assign run_en      = (state_q == RUN);
`endif

    prc_sat_counter #(
        .W (CW)
    ) u_cyc_cnt (
        .clk        (clk),
        .rst_n      (reset),
        .clr_i      (cnt_clr),
        .en_i       (run_en),
        .cnt_o      (cyc_cnt),
        .cnt_next_o (cnt_next)
    );

    // The terminating cycle is itself counted, so the watchdog looks at the
    // count including the current cycle.
    always_comb begin
        exit_hit   = 1'b0;
        exit_cause = EXIT_HALT;
        if (run_en) begin
            if (halt) begin
                exit_hit   = 1'b1;
                exit_cause = EXIT_HALT;
            end else if (prog_ctr == D'(END_PC)) begin
                exit_hit   = 1'b1;
                exit_cause = EXIT_END;
            end else if (cnt_next >= CW'(MAX_CYC)) begin
                exit_hit   = 1'b1;
                exit_cause = EXIT_TMO;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tmo_d   = tmo_q;
        cnt_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = INIT;
                    addr_d  = '0;
                    tmo_d   = 1'b0;
                    cnt_clr = 1'b1;
                end
            end
            INIT: begin
                addr_d = addr_q + AW'(1);
                if (addr_q == AW'(RF_DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (exit_hit) begin
                    state_d = DONE;
                    tmo_d   = (exit_cause == EXIT_TMO);
                end
            end
            DONE: begin
                if (!req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tmo_q   <= tmo_d;
        end
    end

    assign core_rst    = (state_q == IDLE) || (state_q == INIT);
    assign core_en     = run_en;
    assign rf_clr_we   = (state_q == INIT);
    assign rf_clr_addr = addr_q;
    assign busy        = (state_q == INIT) || (state_q == RUN);
    assign done        = (state_q == DONE);
    assign timeout     = tmo_q;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Scoreboard bench for prog_run_ctrl: each run's expected end result is
// queued at issue time and checked by a monitor when done rises.
module tb_prog_run_ctrl;
    import prog_ctrl_pkg::*;

    localparam int D    = 12;
    localparam int RF   = 8;
    localparam int CW   = 16;
    localparam int MAXC = 50;
    localparam int ENDV = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          req;
    logic          halt;
    logic          step;
    logic [D-1:0]  prog_ctr;
    logic          core_rst;
    logic          core_en;
    logic          rf_clr_we;
    logic [2:0]    rf_clr_addr;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cyc_cnt;

    typedef struct {
        prc_exit_t cause;
        logic      tmo;
        int        cyc;
    } exp_t;

    exp_t scoreQ[$];
    int   nTests    = 0;
    int   nFail     = 0;
    int   doneCount = 0;
    logic prevDone  = 1'b0;

    prog_run_ctrl #(
        .D        (D),
        .END_PC   (ENDV),
        .RF_DEPTH (RF),
        .CW       (CW),
        .MAX_CYC  (MAXC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .prog_ctr    (prog_ctr),
        .halt        (halt),
        .step        (step),
        .core_rst    (core_rst),
        .core_en     (core_en),
        .rf_clr_we   (rf_clr_we),
        .rf_clr_addr (rf_clr_addr),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .cyc_cnt     (cyc_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nTests++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " core_rst"}, core_rst, 1);
        checkOutput({tag, " core_en"}, core_en, 0);
        checkOutput({tag, " rf_clr_we"}, rf_clr_we, 0);
        checkOutput({tag, " rf_clr_addr"}, rf_clr_addr, 0);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " done"}, done, 0);
        checkOutput({tag, " timeout"}, timeout, 0);
        checkOutput({tag, " cyc_cnt"}, cyc_cnt, 0);
    endtask

    // Reference: the run ends at the earliest of halt / END_PC / watchdog,
    // halt and END_PC winning over the watchdog on the same cycle.
    task automatic applyStimulus(input int haltAt, input int endAt, input int abortAt);
        exp_t e;
        int   first;
        int   lastCyc;
        int   startDone;
        first = MAXC + 1;
        if (haltAt > 0 && haltAt < first) first = haltAt;
        if (endAt > 0 && endAt < first) first = endAt;
        if (first <= MAXC) begin
            e.cyc   = first;
            e.cause = (haltAt == first) ? EXIT_HALT : EXIT_END;
        end else begin
            e.cyc   = MAXC;
            e.cause = EXIT_TMO;
        end
        e.tmo   = (e.cause == EXIT_TMO);
        lastCyc = (abortAt > 0) ? abortAt : e.cyc;
        if (abortAt == 0) scoreQ.push_back(e);
        startDone = doneCount;

        @(negedge clk);
        req = 1'b1;
        for (int k = 1; k <= RF; k++) begin
            @(negedge clk);
            checkOutput("init rf_clr_we", rf_clr_we, 1);
            checkOutput("init rf_clr_addr", rf_clr_addr, k - 1);
            checkOutput("init busy", busy, 1);
            checkOutput("init core_rst", core_rst, 1);
            checkOutput("init core_en", core_en, 0);
            halt     = 1'($urandom_range(0, 1));
            prog_ctr = (k == RF) ? D'(ENDV) : D'($urandom_range(0, 255));
            req      = 1'($urandom_range(0, 1));
            step     = 1'($urandom_range(0, 1));
        end

        for (int r = 1; r <= lastCyc; r++) begin
            @(negedge clk);
            checkOutput("run core_en", core_en, 1);
            checkOutput("run core_rst", core_rst, 0);
            checkOutput("run done", done, 0);
            halt     = (r == haltAt);
            prog_ctr = (endAt > 0 && r >= endAt) ? D'(ENDV) : D'($urandom_range(0, 127));
            req      = 1'($urandom_range(0, 1));
            step     = 1'($urandom_range(0, 1));
            if (r == abortAt) begin
                #2 reset = 1'b0;
                #1 checkResetValues("async abort");
                @(negedge clk);
                reset = 1'b1;
                req   = 1'b0;
                halt  = 1'b0;
                return;
            end
        end

        for (int i = 0; i < 20 && doneCount == startDone; i++) begin
            @(negedge clk);
            halt     = 1'b0;
            prog_ctr = D'($urandom_range(0, 127));
            req      = 1'b1;
        end
        if (doneCount == startDone) begin
            nTests++;
            nFail++;
            $display("[TB] FAIL done wait: got no done within bound, expected done after %0d cycles", e.cyc);
        end

        repeat (3) begin
            @(negedge clk);
            checkOutput("done held with req", done, 1);
            checkOutput("cyc_cnt held", cyc_cnt, e.cyc);
            checkOutput("timeout held", timeout, e.tmo);
        end
        req = 1'b0;
        @(negedge clk);
        checkOutput("back to idle done", done, 0);
        checkOutput("back to idle core_rst", core_rst, 1);
        checkOutput("back to idle busy", busy, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done && !prevDone) begin
            doneCount++;
            if (scoreQ.size() == 0) begin
                nTests++;
                nFail++;
                $display("[TB] FAIL unexpected done: got done=1, expected no pending run");
            end else begin
                e = scoreQ.pop_front();
                checkOutput("sb timeout", timeout, e.tmo);
                checkOutput("sb cyc_cnt", cyc_cnt, e.cyc);
                checkOutput("sb core_en", core_en, 0);
                checkOutput("sb core_rst", core_rst, 0);
                checkOutput("sb busy", busy, 0);
            end
        end
        prevDone = done;
    end

    initial begin
        int h;
        int en;
        reset    = 1'b0;
        req      = 1'b0;
        halt     = 1'b0;
        step     = 1'b0;
        prog_ctr = '0;
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        reset = 1'b1;

        applyStimulus(0, 40, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(MAXC, MAXC, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 10);
        applyStimulus(3, 0, 0);
        for (int n = 0; n < 6; n++) begin
            h  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 60));
            en = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 60));
            applyStimulus(h, en, 0);
        end

        repeat (2) @(negedge clk);
        checkOutput("scoreboard drained", scoreQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global time limit: got no finish, expected finish");
        $fatal(1, "[TB] time limit");
    end

endmodule
